// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote result reader.
// Holds the FSM state enum, the frame header default, frame length and winner-byte packing.
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [7:0] HEADER_DEF = 8'hA5;

    function automatic int frame_len(input int n);
        return n + 3;
    endfunction

    function automatic logic [7:0] pack_win(input logic t, input logic [2:0] w);
        return {t, 4'b0000, w};
    endfunction

endpackage

// File: rtl/vote_result_reader_if.sv
// Byte stream valid/ready bundle between the result reader and its sink.
// Ports: out_data/out_valid/out_last from master, out_ready from slave.
interface vote_result_reader_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/vote_byte_tx.sv
// Frame byte sender: byte index, output mux, running XOR checksum, handshake.
// Ports: clk, reset (async low), launch, snap, win_byte, bus (master), last_xfer, done.
module vote_byte_tx
    import vote_pkg::*;
#(
    parameter int         NUM_CAND = 4,
    parameter logic [7:0] HEADER   = HEADER_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       launch,
    input  logic [7:0] snap [NUM_CAND],
    input  logic [7:0] win_byte,
    vote_result_reader_if.master bus,
    output logic       last_xfer,
    output logic       done
);

    localparam int LEN = frame_len(NUM_CAND);
    localparam int IW  = $clog2(NUM_CAND);

    logic [3:0]    bidx;
    logic          valid_q;
    logic [7:0]    xor_acc;
    logic [7:0]    byte_mux;
    logic [IW-1:0] si;
    logic          is_last;
    logic          xfer;

    assign si      = IW'(bidx - 4'd1);
    assign is_last = (bidx == 4'(LEN - 1));
    assign xfer    = valid_q && bus.out_ready;

    // Byte 0 is the header, then the snapshot, the winner byte,
    // and finally the checksum of everything already sent.
    always_comb begin
        byte_mux = xor_acc;
        if (bidx == 4'd0)
            byte_mux = HEADER;
        else if (bidx <= 4'(NUM_CAND))
            byte_mux = snap[si];
        else if (bidx == 4'(NUM_CAND + 1))
            byte_mux = win_byte;
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = valid_q ? byte_mux : 8'h00;
    assign bus.out_last  = valid_q && is_last;
    assign last_xfer     = xfer && is_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            bidx    <= 4'd0;
            xor_acc <= 8'h00;
            done    <= 1'b0;
        end else begin
            done <= last_xfer;
            if (launch) begin
                valid_q <= 1'b1;
                bidx    <= 4'd0;
                xor_acc <= 8'h00;
            end else if (xfer) begin
                xor_acc <= xor_acc ^ byte_mux;
                if (is_last)
                    valid_q <= 1'b0;
                else
                    bidx <= bidx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/vote_result_reader.sv
// Result-mode reader: snapshots candidate counts, finds winner/tie/total, streams a frame.
// Ports: clk, reset (async low), mode, start, cand_votes, bus (master), busy, winner, tie, total, done.
module vote_result_reader
    import vote_pkg::*;
#(
    parameter int         NUM_CAND = 4,
    parameter logic [7:0] HEADER   = HEADER_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  start,
    input  logic [8*NUM_CAND-1:0] cand_votes,
    vote_result_reader_if.master  bus,
    output logic                  busy,
    output logic [2:0]            winner,
    output logic                  tie,
    output logic [10:0]           total,
    output logic                  done
);

    localparam int IW = $clog2(NUM_CAND);

    state_t        state;
    logic [7:0]    snap [NUM_CAND];
    logic [IW-1:0] idx;
    logic [10:0]   acc;
    logic [7:0]    best;
    logic [IW-1:0] bsel;
    logic          t_r;

    logic [7:0]    cur;
    logic          first, gt, eq;
    logic [7:0]    n_best;
    logic [IW-1:0] n_sel;
    logic          n_t;
    logic [10:0]   n_acc;
    logic          cmp_end;
    logic          last_xfer;

    assign cur     = snap[idx];
    assign first   = (idx == '0);
    assign gt      = cur > best;
    assign eq      = cur == best;
    // Strict greater-than keeps the lower index on equal counts.
    assign n_best  = (first || gt) ? cur : best;
    assign n_sel   = first ? '0 : (gt ? idx : bsel);
    assign n_t     = first ? 1'b0 : (gt ? 1'b0 : (eq ? 1'b1 : t_r));
    assign n_acc   = (first ? 11'd0 : acc) + {3'b000, cur};
    assign cmp_end = (state == CMP) && (idx == IW'(NUM_CAND - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            idx    <= '0;
            acc    <= 11'd0;
            best   <= 8'h00;
            bsel   <= '0;
            t_r    <= 1'b0;
            winner <= 3'd0;
            tie    <= 1'b0;
            total  <= 11'd0;
            for (int i = 0; i < NUM_CAND; i++)
                snap[i] <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && mode) begin
                        for (int i = 0; i < NUM_CAND; i++)
                            snap[i] <= cand_votes[8*i +: 8];
                        busy  <= 1'b1;
                        idx   <= '0;
                        state <= CMP;
                    end
                end
                CMP: begin
                    acc  <= n_acc;
                    best <= n_best;
                    bsel <= n_sel;
                    t_r  <= n_t;
                    if (cmp_end) begin
                        winner <= 3'(n_sel);
                        tie    <= n_t;
                        total  <= n_acc;
                        state  <= SEND;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SEND: begin
                    if (last_xfer) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    vote_byte_tx #(
        .NUM_CAND (NUM_CAND),
        .HEADER   (HEADER)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .launch    (cmp_end),
        .snap      (snap),
        .win_byte  (pack_win(tie, winner)),
        .bus       (bus),
        .last_xfer (last_xfer),
        .done      (done)
    );

endmodule

// File: tb/tb_vote_result_reader.sv
// Directed scoreboard bench for vote_result_reader (NUM_CAND=4).
// Expected frames are modelled and queued at start; bytes are popped as the DUT presents them.
module tb_vote_result_reader;
    import vote_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cand_votes = 32'h0;
    logic        busy;
    logic [2:0]  winner;
    logic        tie;
    logic [10:0] total;
    logic        done;

    vote_result_reader_if bus ();

    vote_result_reader dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .start      (start),
        .cand_votes (cand_votes),
        .bus        (bus),
        .busy       (busy),
        .winner     (winner),
        .tie        (tie),
        .total      (total),
        .done       (done)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q [$];
    logic [2:0]  exp_win;
    logic        exp_tie;
    logic [10:0] exp_tot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] c0, c1, c2, c3);
        logic [7:0] c [4];
        logic [7:0] x;
        logic [7:0] best;
        c = '{c0, c1, c2, c3};
        best = c[0];
        exp_win = 3'd0;
        exp_tie = 1'b0;
        exp_tot = 11'd0;
        for (int i = 0; i < 4; i++) begin
            exp_tot = exp_tot + {3'b000, c[i]};
            if (i > 0 && c[i] > best) begin
                best = c[i];
                exp_win = 3'(i);
                exp_tie = 1'b0;
            end else if (i > 0 && c[i] == best) begin
                exp_tie = 1'b1;
            end
        end
        x = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(c[i]);
            x = x ^ c[i];
        end
        exp_q.push_back({exp_tie, 4'b0000, exp_win});
        x = x ^ {exp_tie, 4'b0000, exp_win};
        exp_q.push_back(x);
    endtask

    task automatic start_frame(input logic [7:0] c0, c1, c2, c3);
        @(negedge clk);
        cand_votes = {c3, c2, c1, c0};
        push_frame(c0, c1, c2, c3);
        mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic drain(input int stall_byte, input int stall_n,
                         input bit poke, input int abort_byte);
        int nb = 0;
        int lat = 0;
        int guard = 0;
        bit seen = 0;
        bit aborted = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 200) begin
            guard++;
            if (!bus.out_valid) begin
                if (seen) chk("bubble_valid", 32'(bus.out_valid), 32'd1);
                else lat++;
            end else begin
                if (!seen) begin
                    seen = 1;
                    chk("first_latency", lat, 4);
                    chk("winner", 32'(winner), 32'(exp_win));
                    chk("tie", 32'(tie), 32'(exp_tie));
                    chk("total", 32'(total), 32'(exp_tot));
                end
                chk("byte", 32'(bus.out_data), 32'(exp_q[0]));
                chk("last", 32'(bus.out_last), 32'(exp_q.size() == 1));
                if (nb == abort_byte) begin
                    #2 reset = 1'b0;
                    #1;
                    chk("abort_valid", 32'(bus.out_valid), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    exp_q.delete();
                    aborted = 1;
                    break;
                end
                if (nb == stall_byte && stall_n > 0) begin
                    bus.out_ready = 1'b0;
                    repeat (stall_n) begin
                        @(negedge clk);
                        chk("stall_data", 32'(bus.out_data), 32'(exp_q[0]));
                        chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    end
                    bus.out_ready = 1'b1;
                end
                if (poke && nb == 3) begin
                    cand_votes = 32'hDEADBEEF;
                    start = 1'b1;
                    mode = 1'b0;
                end else begin
                    start = 1'b0;
                end
                void'(exp_q.pop_front());
                nb++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("frame_complete", exp_q.size(), 0);
        if (!aborted) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_valid", 32'(bus.out_valid), 32'd0);
            chk("end_last", 32'(bus.out_last), 32'd0);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        int v = 0;
        int d = 0;
        int b = 0;
        repeat (n) begin
            @(negedge clk);
            v += int'(bus.out_valid);
            d += int'(done);
            b += int'(busy);
        end
        chk({tag, "_valid"}, v, 0);
        chk({tag, "_done"}, d, 0);
        chk({tag, "_busy"}, b, 0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        cand_votes = 32'h05020703;
        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_tie", 32'(tie), 32'd0);
        chk("rst_total", 32'(total), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle_check("idle", 10);

        start_frame(8'd3, 8'd7, 8'd2, 8'd5);
        drain(-1, 0, 0, -1);

        start_frame(8'd4, 8'd9, 8'd9, 8'd0);
        drain(-1, 0, 0, -1);
        start_frame(8'd0, 8'd0, 8'd0, 8'd0);
        drain(-1, 0, 0, -1);

        start_frame(8'd3, 8'd7, 8'd2, 8'd5);
        drain(2, 3, 1, -1);
        idle_check("no_requeue", 10);
        chk("tie_held", 32'(tie), 32'd0);
        chk("total_held", 32'(total), 32'd17);

        @(negedge clk);
        mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle_check("mode0_start", 10);

        start_frame(8'd10, 8'd20, 8'd30, 8'd40);
        drain(-1, 0, 0, 3);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        chk("abort_total_clr", 32'(total), 32'd0);
        reset = 1'b1;
        idle_check("post_abort", 3);

        start_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        drain(-1, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vote_result_reader.md
Name: vote_result_reader

Overview:
- Read side of the vote registers. In result mode, on a request, it snapshots all candidate counts.
- It finds the winner and the total with a sequential compare, then streams a byte frame over a valid/ready interface.
- Sits beside the vote logger and feeds the UART/display path; it does not disturb the live counters.

Parameters:
- NUM_CAND, 4, number of candidates; legal range 2..8.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset); one clock domain.
- mode  in  1  0 = voting, 1 = result.
- start  in  1  read request, sampled each edge.
- cand_votes  in  8*NUM_CAND  count of candidate i in bits [8i+7:8i].
- out_data  out  8  frame byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts byte.
- out_last  out  1  high with the final frame byte.
- busy  out  1  frame in progress.
- winner  out  3  index of highest count.
- tie  out  1  two or more candidates share the maximum.
- total  out  11  sum of all counts.
- done  out  1  one-cycle pulse after the last byte handshake.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - out_data, out_valid, out_last, busy, winner, tie, total, done are all 0.
  - Snapshot registers are cleared.
- States: IDLE, CMP, SEND.
- IDLE:
  - start=1 and mode=1 at edge E0: latch all of cand_votes into snapshot regs, busy=1, idx=0, go to CMP.
  - start while mode=0 is ignored.
- CMP: one candidate per edge, E0+1 .. E0+NUM_CAND.
  - Running sum: acc += snap[idx].
  - idx=0: best=snap[0], bidx=0, t=0.
  - idx>0, snap[idx] > best: best=snap[idx], bidx=idx, t=0.
  - idx>0, snap[idx] == best: t=1.
  - Lower index wins on equality.
  - At edge E0+NUM_CAND:
    - winner=bidx, tie=t, total=acc are registered together.
    - Enter SEND with out_valid=1 and out_data=HEADER.
    - For NUM_CAND=4, out_valid is first high after edge E0+4.
- SEND frame, NUM_CAND+3 bytes, in order:
  - HEADER.
  - snap[0] .. snap[NUM_CAND-1].
  - Winner byte = {tie, 4'b0, winner[2:0]}.
  - Checksum = XOR of all preceding frame bytes.
- Handshake:
  - A byte transfers on an edge where out_valid & out_ready.
  - The next byte is presented the following cycle with out_valid held high, so zero bubbles when out_ready stays 1.
  - While out_valid & !out_ready, out_data and out_last hold stable; out_valid is never withdrawn.
  - out_last=1 only while the checksum byte is presented.
- Frame end, on the edge the checksum transfers:
  - out_valid=0, out_last=0, busy=0, done=1 for exactly one cycle, return to IDLE.
  - A new start is accepted the cycle after done.
- winner, tie and total hold their values until the next CMP completes.
- Boundary conditions:
  - start while busy: ignored, no queuing.
  - mode falling to 0 mid-frame: no effect; the frame completes from the snapshot.
  - cand_votes changing after E0: no effect on the current frame.
  - All counts equal (including all zero): winner=0, tie=1.
  - total width is 11 bits, so NUM_CAND*255 never overflows.
  - Reset mid-frame: immediate abort; all outputs go to their reset values and no done pulse is issued.

Decomposition:
- Shared package vote_pkg:
  - state enum (IDLE/CMP/SEND);
  - HEADER default constant;
  - FRAME_LEN(NUM_CAND) = NUM_CAND+3;
  - winner-byte packing function.
- One natural sub-module, vote_byte_tx: byte-index counter, output mux, running XOR, valid/ready/last logic.
- The top-level module keeps the FSM, the snapshot registers and the max/sum datapath.

Test Plan:
- Reset with counts nonzero -> out_valid, busy, done, winner, tie, total all 0; release reset, idle 10 cycles -> no out_valid.
- Counts 3,7,2,5; mode=1; start one cycle; out_ready=1 -> bytes A5,03,07,02,05,01,A7 on 7 consecutive cycles; out_last only on A7; winner=1, tie=0, total=17; done one pulse.
- Counts 4,9,9,0 -> winner byte 81, checksum 20, winner=1, tie=1. Then counts all 0 -> bytes A5,00,00,00,00,80,25, winner=0, tie=1.
- Backpressure and stability: counts 3,7,2,5; out_ready=0 for 3 cycles while 07 is presented -> out_data stays 07 and out_valid stays 1. Change cand_votes mid-frame -> the same frame A5..A7 is emitted.
- Ignored starts:
  - start with mode=0 -> busy stays 0, no bytes.
  - second start during SEND -> no extra frame; exactly one done.
- Abort and restart: reset=0 asserted asynchronously during byte 3 -> out_valid and busy drop without waiting for clk. After release, start gives a full fresh frame beginning with A5.
